hex_seg_driver: RTL and testbench



---
 rtl/hex_seg_pkg.sv | 36 +++
 rtl/hex_seg_decoder.sv | 15 +
 rtl/hex_seg_driver.sv | 103 ++++++++++
 tb/tb_hex_seg_driver.sv | 180 ++++++++++++++++++
 4 files changed

// File: rtl/hex_seg_pkg.sv
// Shared constants, types and hex-digit segment table for the HEX seven-segment driver.
package hex_seg_pkg;

    localparam int unsigned SEG_W    = 8;
    localparam int unsigned BRIGHT_W = 4;

    localparam logic [SEG_W-1:0] SEG_BLANK = 8'hFF;

    typedef logic [BRIGHT_W-1:0] bright_t;

    // Active-low gfedcba pattern for one hex digit.
    function automatic logic [6:0] hex_to_seg(input logic [3:0] digit);
        logic [6:0] seg;
        case (digit)
            4'h0:    seg = 7'h40;
            4'h1:    seg = 7'h79;
            4'h2:    seg = 7'h24;
            4'h3:    seg = 7'h30;
            4'h4:    seg = 7'h19;
            4'h5:    seg = 7'h12;
            4'h6:    seg = 7'h02;
            4'h7:    seg = 7'h78;
            4'h8:    seg = 7'h00;
            4'h9:    seg = 7'h10;
            4'hA:    seg = 7'h08;
            4'hB:    seg = 7'h03;
            4'hC:    seg = 7'h46;
            4'hD:    seg = 7'h21;
            4'hE:    seg = 7'h06;
            4'hF:    seg = 7'h0E;
            default: seg = 7'h7F;
        endcase
        return seg;
    endfunction

endpackage

// File: rtl/hex_seg_decoder.sv
// Hex digit plus decimal-point flag to active-low {dp,g..a} segment pattern.
module hex_seg_decoder
    import hex_seg_pkg::*;
(
    input  logic [SEG_W-1:0] seg_i,
    output logic [SEG_W-1:0] pattern_c_o
);

    // Upper nibble bits above the DP flag carry no meaning here.
    logic unused_c;
    assign unused_c = ^seg_i[7:5];

    assign pattern_c_o = {~seg_i[4], hex_to_seg(seg_i[3:0])};

endmodule

// File: rtl/hex_seg_driver.sv
// Seven-segment digit driver with pattern latch, PWM dimming and blinking.
// Define HEX_SEG_DECODE_EN to decode seg_in as a hex digit instead of raw segment bits.
module hex_seg_driver
    import hex_seg_pkg::*;
#(
    parameter int unsigned PWM_DIV    = 16,
    parameter int unsigned BLINK_HALF = 25_000_000
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [SEG_W-1:0] seg_in,
    input  logic             seg_load,
    input  bright_t          brightness,
    input  logic             blink_en,
    output logic [SEG_W-1:0] hex_out,
    output logic             update_pulse
);

    localparam int unsigned PRE_W   = (PWM_DIV > 1) ? $clog2(PWM_DIV) : 1;
    localparam int unsigned BLINK_W = $clog2(BLINK_HALF);

    localparam logic [PRE_W-1:0]   PRE_LAST   = PRE_W'(PWM_DIV - 1);
    localparam logic [BLINK_W-1:0] BLINK_LAST = BLINK_W'(BLINK_HALF - 1);

    logic [SEG_W-1:0]    pattern_c;
    logic [SEG_W-1:0]    seg_q, seg_d;
    logic                upd_q, upd_d;
    logic [PRE_W-1:0]    pre_cnt_q, pre_cnt_d;
    bright_t             phase_q, phase_d;
    logic [BLINK_W-1:0]  blink_cnt_q, blink_cnt_d;
    logic                vis_q, vis_d;
    logic [SEG_W-1:0]    hex_q, hex_d;
    logic                pre_wrap_c;
    logic                pwm_on_c;

`ifdef HEX_SEG_DECODE_EN
    hex_seg_decoder u_decoder (
        .seg_i       (seg_in),
        .pattern_c_o (pattern_c)
    );
`else
    assign pattern_c = seg_in;
`endif

    // Next-state for pattern latch, change detect, PWM phase, blink and output.
    always_comb begin
        seg_d       = seg_q;
        upd_d       = 1'b0;
        pre_cnt_d   = pre_cnt_q + PRE_W'(1);
        phase_d     = phase_q;
        blink_cnt_d = blink_cnt_q;
        vis_d       = vis_q;
        pre_wrap_c  = (pre_cnt_q == PRE_LAST);
        pwm_on_c    = (brightness == 4'hF) | (phase_q < brightness);

        if (seg_load) begin
            seg_d = pattern_c;
            upd_d = (pattern_c != seg_q);
        end

        if (pre_wrap_c) begin
            pre_cnt_d = '0;
            phase_d   = phase_q + 4'd1;
        end

        // A load restarts the visible half-period, even during a blink wrap.
        if (seg_load || !blink_en) begin
            blink_cnt_d = '0;
            vis_d       = 1'b1;
        end else if (blink_cnt_q == BLINK_LAST) begin
            blink_cnt_d = '0;
            vis_d       = ~vis_q;
        end else begin
            blink_cnt_d = blink_cnt_q + BLINK_W'(1);
        end

        hex_d = (pwm_on_c && vis_q) ? seg_q : SEG_BLANK;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            seg_q       <= SEG_BLANK;
            upd_q       <= 1'b0;
            pre_cnt_q   <= '0;
            phase_q     <= '0;
            blink_cnt_q <= '0;
            vis_q       <= 1'b1;
            hex_q       <= SEG_BLANK;
        end else begin
            seg_q       <= seg_d;
            upd_q       <= upd_d;
            pre_cnt_q   <= pre_cnt_d;
            phase_q     <= phase_d;
            blink_cnt_q <= blink_cnt_d;
            vis_q       <= vis_d;
            hex_q       <= hex_d;
        end
    end

    assign hex_out      = hex_q;
    assign update_pulse = upd_q;

endmodule

// File: tb/tb_hex_seg_driver.sv
// Directed self-checking bench for hex_seg_driver with PWM_DIV=2, BLINK_HALF=8.
module tb_hex_seg_driver;
    import hex_seg_pkg::*;

    logic       clk = 1'b0;
    logic       reset;
    logic [7:0] seg_in;
    logic       seg_load;
    bright_t    brightness;
    logic       blink_en;
    logic [7:0] hex_out;
    logic       update_pulse;

    int n_cmp = 0;
    int n_err = 0;

    logic [7:0] pat_in, pat, pat2_in, pat2;
    int         on_cnt, off_cnt, bad_cnt;

    always #5 clk = ~clk;

    hex_seg_driver #(
        .PWM_DIV    (2),
        .BLINK_HALF (8)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .seg_in       (seg_in),
        .seg_load     (seg_load),
        .brightness   (brightness),
        .blink_en     (blink_en),
        .hex_out      (hex_out),
        .update_pulse (update_pulse)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    initial begin
        reset      = 1'b1;
        seg_load   = 1'b0;
        seg_in     = 8'h00;
        brightness = 4'hF;
        blink_en   = 1'b0;
        tick();
        tick();
        check("rst_hex", hex_out, 8'hFF);
        check("rst_upd", {7'b0, update_pulse}, 8'h00);
        reset = 1'b0;

        for (int i = 0; i < 40; i++) begin
            tick();
            check("idle_hex", hex_out, 8'hFF);
            check("idle_upd", {7'b0, update_pulse}, 8'h00);
        end

`ifdef HEX_SEG_DECODE_EN
        // Digit 8 with DP lights every segment.
        seg_in = 8'h18; seg_load = 1'b1;
        tick();
        seg_load = 1'b0;
        check("dec8_upd", {7'b0, update_pulse}, 8'h01);
        check("dec8_lat", hex_out, 8'hFF);
        tick();
        check("dec8_hex", hex_out, 8'h00);
        seg_in = 8'h0F; seg_load = 1'b1;
        tick();
        seg_load = 1'b0;
        check("decF_upd", {7'b0, update_pulse}, 8'h01);
        tick();
        check("decF_hex", hex_out, 8'h8E);
        // Bits 7:5 are ignored, so this reload is not a change.
        seg_in = 8'hEF; seg_load = 1'b1;
        tick();
        seg_load = 1'b0;
        check("decF_same_upd", {7'b0, update_pulse}, 8'h00);
        tick();
        check("decF_same_hex", hex_out, 8'h8E);
        pat_in = 8'h0F; pat = 8'h8E; pat2_in = 8'h02; pat2 = 8'hA4;
`else
        seg_in = 8'hA4; seg_load = 1'b1;
        tick();
        seg_load = 1'b0;
        check("raw_upd", {7'b0, update_pulse}, 8'h01);
        check("raw_lat", hex_out, 8'hFF);
        tick();
        check("raw_hex", hex_out, 8'hA4);
        check("raw_upd_end", {7'b0, update_pulse}, 8'h00);
        for (int i = 0; i < 5; i++) begin
            tick();
            check("raw_hold", hex_out, 8'hA4);
        end
        seg_load = 1'b1;
        tick();
        seg_load = 1'b0;
        check("raw_same_upd", {7'b0, update_pulse}, 8'h00);
        tick();
        check("raw_same_upd2", {7'b0, update_pulse}, 8'h00);
        check("raw_same_hex", hex_out, 8'hA4);
        pat_in = 8'hA4; pat = 8'hA4; pat2_in = 8'h12; pat2 = 8'h12;
`endif

        // brightness 4: 4 of 16 phases lit, 2 cycles each.
        brightness = 4'd4;
        tick();
        on_cnt = 0; off_cnt = 0; bad_cnt = 0;
        for (int i = 0; i < 32; i++) begin
            tick();
            if (hex_out === pat) on_cnt++;
            else if (hex_out === 8'hFF) off_cnt++;
            else bad_cnt++;
        end
        check("pwm4_on", 8'(on_cnt), 8'd8);
        check("pwm4_off", 8'(off_cnt), 8'd24);
        check("pwm4_bad", 8'(bad_cnt), 8'd0);

        brightness = 4'd0;
        tick();
        on_cnt = 0;
        for (int i = 0; i < 32; i++) begin
            tick();
            if (hex_out !== 8'hFF) on_cnt++;
        end
        check("pwm0_lit", 8'(on_cnt), 8'd0);

        // Blink: reload the same value to pin the blink phase.
        brightness = 4'hF; blink_en = 1'b1;
        seg_in = pat_in; seg_load = 1'b1;
        tick();
        seg_load = 1'b0;
        check("blink_reload_upd", {7'b0, update_pulse}, 8'h00);
        for (int i = 0; i < 24; i++) begin
            tick();
            check("blink_run", hex_out, (((i / 8) % 2) == 0) ? pat : 8'hFF);
        end
        for (int i = 0; i < 3; i++) begin
            tick();
            check("blink_dark", hex_out, 8'hFF);
        end
        seg_in = pat2_in; seg_load = 1'b1;
        tick();
        seg_load = 1'b0;
        check("blink_load_lat", hex_out, 8'hFF);
        check("blink_load_upd", {7'b0, update_pulse}, 8'h01);
        for (int i = 0; i < 8; i++) begin
            tick();
            check("blink_restart", hex_out, pat2);
        end
        tick();
        check("blink_restart_end", hex_out, 8'hFF);

        // Reset mid-blink, with a coincident load that must lose.
        reset = 1'b1; seg_in = pat_in; seg_load = 1'b1;
        tick();
        check("rst2_hex", hex_out, 8'hFF);
        check("rst2_upd", {7'b0, update_pulse}, 8'h00);
        seg_load = 1'b0;
        tick();
        reset = 1'b0;
        for (int i = 0; i < 20; i++) begin
            tick();
            check("post_rst_hex", hex_out, 8'hFF);
            check("post_rst_upd", {7'b0, update_pulse}, 8'h00);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
